// File: rtl/regfile_dump.sv
// Sequential read-out engine: walks an address range through a registered
// register-file read port and streams each word, tagged with its address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; busy low
// READ    | rd_addr holds cur_addr so the register file latches the word
// CAPTURE | rd_data valid; word, address and last flag are captured
// OUT     | word presented on the stream until accepted or aborted
module regfile_dump #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, OUT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
    logic [ADDR_W-1:0] end_addr, end_addr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt, out_addr_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              out_valid_nxt, out_last_nxt, done_nxt;
    logic              handshake, at_end;

    assign handshake = out_valid & out_ready;
    assign at_end    = (cur_addr == end_addr);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        end_addr_nxt  = end_addr;
        rd_addr_nxt   = rd_addr;
        out_data_nxt  = out_data;
        out_addr_nxt  = out_addr;
        out_last_nxt  = out_last;
        out_valid_nxt = out_valid;
        done_nxt      = 1'b0;

        // abort beats everything outside IDLE; a pending word is dropped
        if (abort && state != IDLE) begin
            state_nxt     = IDLE;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cur_addr_nxt = first_addr;
                        end_addr_nxt = last_addr;
                        rd_addr_nxt  = first_addr;
                        state_nxt    = READ;
                    end
                end
                READ: state_nxt = CAPTURE;
                CAPTURE: begin
                    out_data_nxt  = rd_data;
                    out_addr_nxt  = cur_addr;
                    out_last_nxt  = at_end;
                    out_valid_nxt = 1'b1;
                    state_nxt     = OUT;
                end
                OUT: begin
                    if (handshake) begin
                        out_valid_nxt = 1'b0;
                        if (at_end) begin
                            out_last_nxt = 1'b0;
                            done_nxt     = 1'b1;
                            state_nxt    = IDLE;
                        end else begin
                            cur_addr_nxt = cur_addr + ADDR_W'(1);
                            rd_addr_nxt  = cur_addr + ADDR_W'(1);
                            state_nxt    = READ;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            end_addr  <= '0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            end_addr  <= end_addr_nxt;
            rd_addr   <= rd_addr_nxt;
            out_data  <= out_data_nxt;
            out_addr  <= out_addr_nxt;
            out_last  <= out_last_nxt;
            out_valid <= out_valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: register-file model, scoreboard of expected
// words pushed at start and popped on each stream handshake.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [3:0]  first_addr, last_addr, rd_addr, out_addr;
    logic [15:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [15:0] rf[16];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    regfile_dump #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // registered read port of the register file
    always @(posedge clk) begin
        rd_data <= rf[rd_addr];
        cyc     <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // handshakes and done pulses, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready && !abort) begin
            hs_cnt++;
            chk("sb_depth", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("word_addr", 32'(out_addr), 32'(e.addr));
                chk("word_data", 32'(out_data), 32'(e.data));
                chk("word_last", 32'(out_last), 32'(e.last));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_valid_excl", 32'(out_valid), 32'd0);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_sb_empty", 32'(q.size()), 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
        logic [3:0] a;
        logic [3:0] diff;
        diff = l - f;
        a    = f;
        for (int i = 0; i <= int'(diff); i++) begin
            q.push_back('{addr: a, data: rf[a], last: (a == l)});
            a = a + 4'd1;
        end
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic take_word(input int hold);
        wait_valid("word_arrives", 20);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            if (q.size() > 0) begin
                chk("hold_data", 32'(out_data), 32'(q[0].data));
                chk("hold_addr", 32'(out_addr), 32'(q[0].addr));
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int t0, h0, d0;
        for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);

        // full dump, stream always ready
        out_ready = 1'b1;
        h0 = hs_cnt;
        start_dump(4'd0, 4'd15);
        t0 = cyc;
        chk("lat_e0_valid", 32'(out_valid), 32'd0);
        chk("lat_e0_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_e1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_e2_valid", 32'(out_valid), 32'd1);
        wait_done("full_done", 80);
        chk("full_cycles", 32'(done_cyc - t0), 32'd48);
        chk("full_words", 32'(hs_cnt - h0), 32'd16);

        // wrap range 14..1
        h0 = hs_cnt;
        start_dump(4'd14, 4'd1);
        wait_done("wrap_done", 40);
        chk("wrap_words", 32'(hs_cnt - h0), 32'd4);

        // single word
        rf[5] = 16'h1234;
        h0 = hs_cnt;
        start_dump(4'd5, 4'd5);
        wait_done("single_done", 20);
        chk("single_words", 32'(hs_cnt - h0), 32'd1);
        tick();
        chk("single_busy_after", 32'(busy), 32'd0);
        rf[5] = 16'hA005;

        // backpressure on word 3
        out_ready = 1'b0;
        h0 = hs_cnt;
        start_dump(4'd0, 4'd5);
        take_word(0);
        take_word(0);
        take_word(0);
        take_word(7);
        chk("bp_hs_valid", 32'(out_valid), 32'd0);
        tick();
        chk("bp_hs1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("bp_hs2_valid", 32'(out_valid), 32'd1);
        chk("bp_next_addr", 32'(out_addr), 32'd4);
        take_word(0);
        take_word(0);
        wait_done("bp_done", 20);
        chk("bp_words", 32'(hs_cnt - h0), 32'd6);

        // start while busy is ignored, then abort on word 4
        start_dump(4'd0, 4'd15);
        take_word(0);
        take_word(0);
        wait_valid("sb_word2", 20);
        first_addr = 4'd8; last_addr = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        take_word(0);
        take_word(0);
        wait_valid("abort_word4", 20);
        chk("abort_word4_addr", 32'(out_addr), 32'd4);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
        q.delete();
        repeat (5) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        out_ready = 1'b1;
        h0 = hs_cnt;
        start_dump(4'd3, 4'd5);
        wait_done("after_abort_done", 20);
        chk("after_abort_words", 32'(hs_cnt - h0), 32'd3);

        // reset in CAPTURE, then reset together with start
        start_dump(4'd0, 4'd3);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_rd_addr", 32'(rd_addr), 32'd0);
        chk("mrst_out_data", 32'(out_data), 32'd0);
        chk("mrst_out_addr", 32'(out_addr), 32'd0);
        chk("mrst_out_last", 32'(out_last), 32'd0);
        q.delete();
        first_addr = 4'd2; last_addr = 4'd3; start = 1'b1;
        tick();
        chk("rst_start_busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rst_start_idle", 32'(busy), 32'd0);
        chk("rst_start_valid", 32'(out_valid), 32'd0);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
Sequential read-out engine for the 16 x 16-bit register file. On a start command it walks an address range through one of the register file's registered read ports. It captures each word one cycle after issuing its address and presents each word, tagged with its address, on a valid/ready stream. The stream feeds debug/trace or host read-back logic.

Parameters:
DATA_W, 16, width of register word and out_data
ADDR_W, 4, register address width; register count is 2**ADDR_W (16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a dump; sampled only in IDLE
abort  input  1  cancel dump in progress; sampled every cycle
first_addr  input  ADDR_W  first register of range, sampled with start
last_addr  input  ADDR_W  last register of range, sampled with start
rd_addr  output  ADDR_W  address to register file read port (registered)
rd_data  input  DATA_W  register file read data; valid the cycle after rd_addr is held for one edge
out_valid  output  1  out_data/out_addr/out_last valid
out_ready  input  1  consumer accepts word when high with out_valid
out_data  output  DATA_W  captured register value
out_addr  output  ADDR_W  address the word was read from
out_last  output  1  high with the final word of the range
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (rst high at an edge, any state): state IDLE; rd_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, internal cur/last regs=0. Reset overrides start/abort and aborts any dump.
- FSM states: IDLE, READ, CAPTURE, OUT.
- IDLE: start=1 at edge -> cur<=first_addr, last<=last_addr, rd_addr<=first_addr, go READ. busy is 1 from the next cycle.
- READ: rd_addr holds cur for this cycle, so the register file latches the word at the end-of-cycle edge. Go CAPTURE unconditionally.
- CAPTURE: rd_data is valid. At the edge: out_data<=rd_data, out_addr<=cur, out_last<=(cur==last), out_valid<=1, go OUT.
- OUT: out_valid=1. out_data, out_addr and out_last stay stable until the handshake (out_valid&out_ready at an edge).
  - On handshake with cur==last: out_valid<=0, out_last<=0, go IDLE, done<=1 for exactly one cycle.
  - On handshake otherwise: out_valid<=0, cur<=cur+1 (mod 2**ADDR_W), rd_addr<=cur+1, go READ.
- Latency:
  - start at edge E0 -> out_valid first high after edge E2.
  - Each handshake edge Ek (non-final) -> next out_valid high after edge Ek+2.
  - Throughput 1 word / 3 cycles with out_ready held high.
- Range/wrap:
  - Word count = ((last_addr - first_addr) mod 2**ADDR_W) + 1.
  - first_addr > last_addr wraps through 15 -> 0.
  - first_addr == last_addr dumps exactly one word.
  - A full 16-word dump uses last_addr = first_addr - 1 (mod 16).
- start while busy: ignored; the range registers are unchanged.
- abort=1 at any edge in READ/CAPTURE/OUT: go IDLE, out_valid<=0, out_last<=0, no done pulse; any word pending in OUT is dropped. abort in IDLE has no effect. abort and start together in IDLE: abort wins, stay IDLE.
- out_ready while out_valid=0 has no effect. Register file contents changing mid-dump are not protected; each word reflects its value at its READ edge.
- done and out_valid are never high in the same cycle.

Test Plan:
- Full dump: preload reg[i]=16'hA000+i; start with first=0, last=15, out_ready=1 -> 16 words, addresses 0..15 in order, data A000..A00F, out_last only on addr 15, done one cycle after the 16th handshake, 48 cycles start-to-done.
- Wrap range: first=14, last=1 -> words from addresses 14,15,0,1 with matching data; out_last on addr 1; exactly 4 handshakes.
- Single word: first=last=5, reg5=16'h1234 -> one word 1234, out_last=1, done after handshake, busy low the following cycle.
- Backpressure: out_ready low for 7 cycles on word 3 -> out_valid, out_data and out_addr held constant throughout; no address skipped or duplicated; next word 2 cycles after the handshake.
- Abort/start-while-busy: start 0..15; pulse start with first=8 at word 2 -> ignored. Assert abort while in OUT on word 4 -> out_valid=0 and busy=0 next cycle, no done pulse; a new start afterwards dumps correctly.
- Reset mid-dump: rst high in CAPTURE -> all outputs at reset values next cycle; rst and start high together -> stays IDLE.
